// File: rtl/stream_pipe_pkg.sv
// Shared types and helpers for the stream_pipe register slice.
package stream_pipe_pkg;

    typedef enum logic {PIPE_FWD, PIPE_SKID} pipe_mode_e;

    typedef enum logic [1:0] {SKID_EMPTY, SKID_HALF, SKID_FULL} skid_state_e;

    // Number of beats the whole pipe can hold.
    function automatic int pipe_cap(input int depth, input int mode);
        return depth * ((mode == int'(PIPE_SKID)) ? 2 : 1);
    endfunction

endpackage

// File: rtl/stream_pipe_stage.sv
// One valid/ready register stage, either forward (FWD) or skid (SKID).
//
// SKID stage states
//   state      | meaning
//   SKID_EMPTY | main and skid empty, ready_o=1
//   SKID_HALF  | main holds a beat, skid empty, ready_o=1
//   SKID_FULL  | main and skid both hold a beat, ready_o=0
module stream_pipe_stage
    import stream_pipe_pkg::*;
#(
    parameter int DW   = 8,
    parameter int MODE = 0
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clear_i,
    input  logic          valid_i,
    output logic          ready_o,
    input  logic [DW-1:0] data_i,
    output logic          valid_o,
    input  logic          ready_i,
    output logic [DW-1:0] data_o
);

    if (MODE == int'(PIPE_SKID)) begin : g_skid
        skid_state_e   state_q, state_d;
        logic [DW-1:0] main_q, main_d;
        logic [DW-1:0] skid_q, skid_d;
        logic          in_fire, out_fire;

        // ready comes straight from a register, which is what cuts the ready path
        assign ready_o  = (state_q != SKID_FULL);
        assign valid_o  = (state_q != SKID_EMPTY);
        assign data_o   = main_q;
        assign in_fire  = valid_i & ready_o;
        assign out_fire = valid_o & ready_i;

        // Next-state and buffer update; clear overrides any handshake
        always_comb begin
            state_d = state_q;
            main_d  = main_q;
            skid_d  = skid_q;
            if (clear_i) begin
                state_d = SKID_EMPTY;
                main_d  = '0;
                skid_d  = '0;
            end else begin
                case (state_q)
                    SKID_EMPTY: begin
                        if (in_fire) begin
                            main_d  = data_i;
                            state_d = SKID_HALF;
                        end
                    end
                    SKID_HALF: begin
                        if (in_fire && out_fire) begin
                            main_d = data_i;
                        end else if (out_fire) begin
                            state_d = SKID_EMPTY;
                        end else if (in_fire) begin
                            skid_d  = data_i;
                            state_d = SKID_FULL;
                        end
                    end
                    SKID_FULL: begin
                        if (out_fire) begin
                            main_d  = skid_q;
                            state_d = SKID_HALF;
                        end
                    end
                    default: state_d = SKID_EMPTY;
                endcase
            end
        end

        // State and buffer registers
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                state_q <= SKID_EMPTY;
                main_q  <= '0;
                skid_q  <= '0;
            end else begin
                state_q <= state_d;
                main_q  <= main_d;
                skid_q  <= skid_d;
            end
        end
    end else begin : g_fwd
        logic          valid_q, valid_d;
        logic [DW-1:0] data_q, data_d;

        assign ready_o = ready_i | ~valid_q;
        assign valid_o = valid_q;
        assign data_o  = data_q;

        // Advance whenever the slot is free or being drained; data only moves on a real beat
        always_comb begin
            valid_d = valid_q;
            data_d  = data_q;
            if (clear_i) begin
                valid_d = 1'b0;
                data_d  = '0;
            end else if (ready_o) begin
                valid_d = valid_i;
                if (valid_i) begin
                    data_d = data_i;
                end
            end
        end

        // Valid and data registers
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                valid_q <= 1'b0;
                data_q  <= '0;
            end else begin
                valid_q <= valid_d;
                data_q  <= data_d;
            end
        end
    end

endmodule

// File: rtl/stream_pipe.sv
// DEPTH cascaded valid/ready register stages of one common type (FWD or SKID).
// Optional STREAM_PIPE_OCCUPANCY_EN adds occ_o, a registered count of beats held.
module stream_pipe
    import stream_pipe_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = 2,
    parameter int MODE  = 0
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clear_i,
    input  logic          valid_i,
    output logic          ready_o,
    input  logic [DW-1:0] data_i,
    output logic          valid_o,
    input  logic          ready_i,
    output logic [DW-1:0] data_o
`ifdef STREAM_PIPE_OCCUPANCY_EN
    ,
    output logic [$clog2(pipe_cap(DEPTH, MODE) + 1) - 1:0] occ_o
`endif
);

    if (DW < 1) begin : g_bad_dw
        $fatal(1, "stream_pipe: DW must be >= 1");
    end
    if (DEPTH < 1) begin : g_bad_depth
        $fatal(1, "stream_pipe: DEPTH must be >= 1");
    end
    if (MODE < 0 || MODE > 1) begin : g_bad_mode
        $fatal(1, "stream_pipe: MODE must be 0 (FWD) or 1 (SKID)");
    end

    // Index k is the input side of stage k; index DEPTH is the pipe output.
    logic          valid_c [DEPTH+1];
    logic          ready_c [DEPTH+1];
    logic [DW-1:0] data_c  [DEPTH+1];

    assign valid_c[0]     = valid_i;
    assign data_c[0]      = data_i;
    assign ready_o        = ready_c[0];
    assign valid_o        = valid_c[DEPTH];
    assign data_o         = data_c[DEPTH];
    assign ready_c[DEPTH] = ready_i;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        stream_pipe_stage #(
            .DW   (DW),
            .MODE (MODE)
        ) u_stage (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .clear_i (clear_i),
            .valid_i (valid_c[k]),
            .ready_o (ready_c[k]),
            .data_i  (data_c[k]),
            .valid_o (valid_c[k+1]),
            .ready_i (ready_c[k+1]),
            .data_o  (data_c[k+1])
        );
    end

`ifdef STREAM_PIPE_OCCUPANCY_EN
    localparam int CAP   = pipe_cap(DEPTH, MODE);
    localparam int OCC_W = $clog2(CAP + 1);

    logic [OCC_W-1:0] occ_q, occ_d;
    logic             in_fire, out_fire;

    assign in_fire  = valid_i & ready_o;
    assign out_fire = valid_o & ready_i;
    assign occ_o    = occ_q;

    // Track beats entering and leaving; simultaneous in/out leaves the count alone
    always_comb begin
        occ_d = occ_q;
        if (clear_i) begin
            occ_d = '0;
        end else if (in_fire && !out_fire) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (out_fire && !in_fire) begin
            occ_d = occ_q - OCC_W'(1);
        end
    end

    // Occupancy register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end
`endif

endmodule

// File: tb/tb_stream_pipe.sv
// Scoreboard bench for stream_pipe: several instances with different DEPTH/MODE.
//   u0: FWD  DEPTH=2   u1: SKID DEPTH=2   u2: SKID DEPTH=1   u3: SKID DEPTH=3 (occupancy build only)
module tb_stream_pipe;

`ifdef STREAM_PIPE_OCCUPANCY_EN
    localparam int NI = 4;
`else
    localparam int NI = 3;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [NI-1:0] vin, rin, clr;
    wire  [NI-1:0] vout, rout;
    logic [7:0]    din  [NI];
    wire  [7:0]    dout [NI];

`ifdef STREAM_PIPE_OCCUPANCY_EN
    wire [1:0] occ0;
    wire [2:0] occ1;
    wire [1:0] occ2;
    wire [2:0] occ3;
    wire [2:0] occv [NI];
    assign occv[0] = {1'b0, occ0};
    assign occv[1] = occ1;
    assign occv[2] = {1'b0, occ2};
    assign occv[3] = occ3;
`endif

    stream_pipe #(.DW(8), .DEPTH(2), .MODE(0)) u0 (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clr[0]), .valid_i(vin[0]), .ready_o(rout[0]),
        .data_i(din[0]), .valid_o(vout[0]), .ready_i(rin[0]), .data_o(dout[0])
`ifdef STREAM_PIPE_OCCUPANCY_EN
        , .occ_o(occ0)
`endif
    );
    stream_pipe #(.DW(8), .DEPTH(2), .MODE(1)) u1 (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clr[1]), .valid_i(vin[1]), .ready_o(rout[1]),
        .data_i(din[1]), .valid_o(vout[1]), .ready_i(rin[1]), .data_o(dout[1])
`ifdef STREAM_PIPE_OCCUPANCY_EN
        , .occ_o(occ1)
`endif
    );
    stream_pipe #(.DW(8), .DEPTH(1), .MODE(1)) u2 (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clr[2]), .valid_i(vin[2]), .ready_o(rout[2]),
        .data_i(din[2]), .valid_o(vout[2]), .ready_i(rin[2]), .data_o(dout[2])
`ifdef STREAM_PIPE_OCCUPANCY_EN
        , .occ_o(occ2)
`endif
    );
`ifdef STREAM_PIPE_OCCUPANCY_EN
    stream_pipe #(.DW(8), .DEPTH(3), .MODE(1)) u3 (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clr[3]), .valid_i(vin[3]), .ready_o(rout[3]),
        .data_i(din[3]), .valid_o(vout[3]), .ready_i(rin[3]), .data_o(dout[3]), .occ_o(occ3)
    );
`endif

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q [NI][$];
    int         n_out   [NI];
    int         occ_exp [NI];
    logic       hold    [NI];
    logic [7:0] hold_d  [NI];
    logic [7:0] sb_w;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic flush_model();
        for (int i = 0; i < NI; i++) begin
            exp_q[i].delete();
            occ_exp[i] = 0;
            hold[i]    = 1'b0;
        end
    endtask

    // Scoreboard monitor: push on input fire, pop and compare on output fire
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < NI; i++) begin
                if (hold[i]) begin
                    chk($sformatf("u%0d_hold_valid", i), 32'(vout[i]), 32'd1);
                    chk($sformatf("u%0d_hold_data", i), 32'(dout[i]), 32'(hold_d[i]));
                end
`ifdef STREAM_PIPE_OCCUPANCY_EN
                chk($sformatf("u%0d_occ", i), 32'(occv[i]), 32'(occ_exp[i]));
`endif
                if (vout[i] && rin[i]) begin
                    n_out[i]++;
                    checks++;
                    if (exp_q[i].size() == 0) begin
                        errors++;
                        $display("FAIL u%0d_order: got %02h, expected no beat", i, dout[i]);
                    end else begin
                        sb_w = exp_q[i].pop_front();
                        if (dout[i] !== sb_w) begin
                            errors++;
                            $display("FAIL u%0d_order: got %02h, expected %02h", i, dout[i], sb_w);
                        end
                    end
                end
                hold[i]   = vout[i] && !rin[i] && !clr[i];
                hold_d[i] = dout[i];
                if (clr[i]) begin
                    exp_q[i].delete();
                    occ_exp[i] = 0;
                end else begin
                    if (vin[i] && rout[i]) exp_q[i].push_back(din[i]);
                    occ_exp[i] += int'(vin[i] && rout[i]) - int'(vout[i] && rin[i]);
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    localparam logic       T1_V  [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam logic [7:0] T1_D  [6] = '{8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00};
    localparam logic       T1_OV [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    localparam logic [7:0] T1_OD [6] = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h33};

    int         d, acc, cnt;
    logic       rb;

    initial begin
        rst_n = 1'b0;
        vin   = '0;
        rin   = '0;
        clr   = '0;
        for (int i = 0; i < NI; i++) begin
            din[i]   = 8'h00;
            n_out[i] = 0;
        end
        flush_model();
        #12;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("rst_valid_u%0d", i), 32'(vout[i]), 32'd0);
            chk($sformatf("rst_data_u%0d", i), 32'(dout[i]), 32'd0);
            chk($sformatf("rst_ready_u%0d", i), 32'(rout[i]), 32'd1);
        end
        #1 rst_n = 1'b1;

        // FWD, DEPTH=2, downstream always ready
        rin[0] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            vin[0] = T1_V[k];
            din[0] = T1_D[k];
            smp();
            chk($sformatf("t1_valid_c%0d", k), 32'(vout[0]), 32'(T1_OV[k]));
            chk($sformatf("t1_data_c%0d", k), 32'(dout[0]), 32'(T1_OD[k]));
            chk($sformatf("t1_ready_c%0d", k), 32'(rout[0]), 32'd1);
        end

        // SKID, DEPTH=2, downstream stalled: only CAP=4 beats get in
        rin[1] = 1'b0;
        d      = 1;
        acc    = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            vin[1] = (d <= 5);
            din[1] = 8'(d);
            smp();
            if (c == 3) chk("t2_ready_before_full", 32'(rout[1]), 32'd1);
            if (c >= 4) chk($sformatf("t2_ready_full_c%0d", c), 32'(rout[1]), 32'd0);
            if (vin[1] && rout[1]) begin
                acc++;
                d++;
            end
        end
        chk("t2_accepted", 32'(acc), 32'd4);
        for (int k = 0; k < 4; k++) begin
            tick();
            vin[1] = 1'b0;
            rin[1] = 1'b1;
            smp();
            chk($sformatf("t2_out_valid_%0d", k), 32'(vout[1]), 32'd1);
            chk($sformatf("t2_out_data_%0d", k), 32'(dout[1]), 32'(k + 1));
            if (k == 2) chk("t2_ready_back", 32'(rout[1]), 32'd1);
        end
        tick();
        smp();
        chk("t2_drained", 32'(vout[1]), 32'd0);

        // Clear on a full SKID pipe with a beat offered in the clear cycle
        rin[1] = 1'b0;
        d      = 16;
        acc    = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            vin[1] = 1'b1;
            din[1] = 8'(d);
            smp();
            if (vin[1] && rout[1]) begin
                acc++;
                d++;
            end
        end
        chk("t4_filled", 32'(acc), 32'd4);
        tick();
        clr[1] = 1'b1;
        vin[1] = 1'b1;
        din[1] = 8'hAA;
        smp();
        chk("t4_ready_in_clear", 32'(rout[1]), 32'd0);
        tick();
        clr[1] = 1'b0;
        vin[1] = 1'b0;
        smp();
        chk("t4_valid_after_clear", 32'(vout[1]), 32'd0);
        chk("t4_data_after_clear", 32'(dout[1]), 32'd0);
        chk("t4_ready_after_clear", 32'(rout[1]), 32'd1);
        rin[1] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            smp();
            chk($sformatf("t4_no_output_c%0d", c), 32'(vout[1]), 32'd0);
        end

        // SKID, DEPTH=1, toggling downstream ready; ready_o must not follow ready_i combinationally
        rin[2] = 1'b0;
        cnt    = 0;
        for (int c = 0; c < 24; c++) begin
            tick();
            vin[2] = 1'b1;
            din[2] = 8'(cnt);
            rb     = rout[2];
            rin[2] = ~rin[2];
            #1;
            chk($sformatf("t3_ready_reg_c%0d", c), 32'(rout[2]), 32'(rb));
            smp();
            if (vin[2] && rout[2]) cnt++;
        end
        tick();
        vin[2] = 1'b0;
        rin[2] = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            smp();
        end
        chk("t3_out_count", 32'(n_out[2]), 32'(cnt));
        chk("t3_queue_empty", 32'(exp_q[2].size()), 32'd0);

        // Asynchronous reset in the middle of a stream
        rin[1] = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            vin[1] = (c < 2);
            din[1] = 8'(8'h31 + c);
            smp();
        end
        chk("t5_before_reset", 32'(dout[1]), 32'h31);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", 32'(vout[1]), 32'd0);
        chk("t5_rst_data", 32'(dout[1]), 32'd0);
        chk("t5_rst_ready", 32'(rout[1]), 32'd1);
        #1 rst_n = 1'b1;
        flush_model();
        tick();
        vin[1] = 1'b1;
        din[1] = 8'h5A;
        rin[1] = 1'b1;
        smp();
        tick();
        vin[1] = 1'b0;
        smp();
        chk("t5_lat_not_yet", 32'(vout[1]), 32'd0);
        tick();
        smp();
        chk("t5_lat_valid", 32'(vout[1]), 32'd1);
        chk("t5_lat_data", 32'(dout[1]), 32'h5A);
        tick();
        smp();

`ifdef STREAM_PIPE_OCCUPANCY_EN
        // Occupancy on SKID DEPTH=3 (CAP=6)
        rin[3] = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            vin[3] = 1'b1;
            din[3] = 8'(8'h40 + c);
            smp();
        end
        chk("t6_occ_full", 32'(occ3), 32'd6);
        rin[3] = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick();
            din[3] = 8'(8'h60 + c);
            smp();
        end
        for (int c = 0; c < 10; c++) begin
            tick();
            vin[3] = 1'b0;
            smp();
        end
        chk("t6_occ_drained", 32'(occ3), 32'd0);
        chk("t6_queue_empty", 32'(exp_q[3].size()), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_pipe.md
Name: stream_pipe

Overview:
- Parametrised valid/ready pipeline of DEPTH back-to-back stream register stages, each DW bits wide.
- Successor to the single-stage forward register.
- Adds selectable stage mode: FWD (combinational ready path) or SKID (registered ready, 2-entry stage, full throughput).
- Used to cut long valid, data and ready timing paths between stream producers and consumers.

Parameters:
DW, 8, payload width in bits (>=1)
DEPTH, 2, number of cascaded stages (>=1)
MODE, 0, stage type: 0 = PIPE_FWD, 1 = PIPE_SKID (applies to all stages)

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
clear_i  in  1  synchronous flush of all stages
valid_i  in  1  upstream valid
ready_o  out  1  upstream ready
data_i  in  DW  upstream payload
valid_o  out  1  downstream valid
ready_i  in  1  downstream ready
data_o  out  DW  downstream payload

Behaviour:
- Reset: all valid flags 0, all data registers 0; valid_o=0, data_o=0, ready_o=1.
- Handshake: a transfer occurs when valid and ready are both 1 at a rising edge. valid_o never depends combinationally on valid_i. Once valid_o=1, it and data_o stay stable until accepted.
- Latency: DEPTH cycles from input acceptance to valid_o when the pipe is empty. Throughput is 1 beat/cycle in both modes. Order is preserved; no beat is lost or duplicated.
- FWD stage:
  - ready_o = ready_i | ~valid_r.
  - If ready_o, valid_r <= valid_i.
  - data_r loads only on input fire.
  - Capacity is 1 beat per stage. ready is combinational through all DEPTH stages.
- SKID stage:
  - Registers: main (v,d) and skid (v,d). ready_o = ~skid_v, so ready is registered.
  - valid_o = main_v; data_o = main_d.
  - States: EMPTY (0,0), HALF (1,0), FULL (1,1).
  - EMPTY: in_fire -> HALF, main <= data_i.
  - HALF, out_fire & in_fire: main <= data_i, stay HALF.
  - HALF, out_fire only: -> EMPTY.
  - HALF, in_fire only: skid <= data_i -> FULL.
  - FULL (ready_o=0): out_fire -> main <= skid, skid_v <= 0 -> HALF.
  - Capacity is 2 beats per stage.
- Total capacity CAP = DEPTH*(MODE?2:1).
- clear_i:
  - Has priority over all activity. Next edge sets all valid flags 0 and all data 0.
  - A beat offered or accepted in the clear cycle is discarded.
  - ready_o in the clear cycle follows current state; do not gate it with clear_i.
- Reset mid-stream: all contents lost immediately (asynchronous). Outputs go to reset values while rst_ni=0.
- Illegal parameters (DEPTH<1, MODE>1): $fatal at elaboration.

Optional Feature:
- Macro STREAM_PIPE_OCCUPANCY_EN.
- Defined: adds output occ_o, width $clog2(CAP+1).
  - Registered count of valid entries across all stages; reset 0, cleared to 0 by clear_i.
  - +1 on input fire only, -1 on output fire only, unchanged when both fire.
  - Equals the sum of all stage valid flags at every cycle.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package stream_pipe_pkg holds:
  - typedef enum logic {PIPE_FWD, PIPE_SKID} pipe_mode_e;
  - function pipe_cap(depth, mode), which returns CAP.
- Sub-module stream_pipe_stage (DW, MODE) implements one stage.
- The top instantiates DEPTH stages in a generate loop, with stage k's output chained to stage k+1's input.

Test Plan:
- MODE=0, DEPTH=2, ready_i=1: drive 0x11,0x22,0x33 on consecutive cycles -> valid_o rises 2 cycles after the first accept; data_o = 0x11,0x22,0x33 on consecutive cycles.
- MODE=1, DEPTH=2, ready_i=0: stream 0x01..0x05 -> exactly 4 accepted, ready_o=0 from the cycle after the 4th accept. Then set ready_i=1 -> outputs 0x01..0x04 in order, ready_o returns to 1 one cycle after the first output fire.
- MODE=1, DEPTH=1, ready_i toggles 1/0 each cycle, valid_i=1 with an incrementing counter -> no loss or duplication, ready_o never changes in the same cycle as ready_i.
- Pipe full with 4 beats (MODE=1, DEPTH=2), pulse clear_i for 1 cycle with valid_i=1, data 0xAA -> next cycle valid_o=0, data_o=0, ready_o=1; 0xAA never appears at the output.
- Assert rst_ni low mid-stream for a partial cycle -> valid_o=0 and data_o=0 immediately; after release the first new beat exits after DEPTH cycles.
- With STREAM_PIPE_OCCUPANCY_EN, MODE=1, DEPTH=3: fill to 6 -> occ_o=6 (width 3); simultaneous in/out fire keeps 6; drain -> 0.
